// File: rtl/palette_rgb_if.sv
// palette_rgb_if -- pixel and palette-write bundle for palette_rgb.
//   color_i/valid_i/blank_i/mode_i : incoming pixel (index, qualifier, blanking, lookup mode)
//   wr_en_i/wr_addr_i/wr_data_i    : palette write port, data packed {red,green,blue}
//   red_o/green_o/blue_o/valid_o   : outgoing pixel, two cycles after the input
//   busy_o                         : high while the palette is being initialised
// Signal suffixes are as seen from the palette_rgb block (slave modport).
interface palette_rgb_if #(
  parameter int IDX_W = 4,
  parameter int R_W   = 5,
  parameter int G_W   = 6,
  parameter int B_W   = 5
);
  localparam int PIX_W = R_W + G_W + B_W;

  logic [IDX_W-1:0] color_i;
  logic             valid_i;
  logic             blank_i;
  logic             mode_i;
  logic             wr_en_i;
  logic [IDX_W-1:0] wr_addr_i;
  logic [PIX_W-1:0] wr_data_i;
  logic [R_W-1:0]   red_o;
  logic [G_W-1:0]   green_o;
  logic [B_W-1:0]   blue_o;
  logic             valid_o;
  logic             busy_o;

  modport master (
    output color_i, valid_i, blank_i, mode_i, wr_en_i, wr_addr_i, wr_data_i,
    input  red_o, green_o, blue_o, valid_o, busy_o
  );

  modport slave (
    input  color_i, valid_i, blank_i, mode_i, wr_en_i, wr_addr_i, wr_data_i,
    output red_o, green_o, blue_o, valid_o, busy_o
  );
endinterface

// File: rtl/palette_rgb.sv
// palette_rgb -- colour index to RGB converter, two-cycle pipeline.
//   clk_i : clock, all logic on rising edge
//   rst_i : synchronous active-high reset; restarts palette initialisation
//   bus   : palette_rgb_if.slave (pixel in, palette write, pixel out, busy)
// Mode 0 expands the index as RGBI; mode 1 looks the index up in a palette RAM.
// After reset the palette is loaded with the RGBI expansion of every index,
// one entry per cycle, while busy_o is high; pixels keep flowing meanwhile
// and are treated as mode 0.
module palette_rgb #(
  parameter int IDX_W = 4,
  parameter int R_W   = 5,
  parameter int G_W   = 6,
  parameter int B_W   = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  palette_rgb_if.slave  bus
);
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             busy;

  logic [PIX_W-1:0] init_pix;   // RGBI expansion of k_q
  logic [PIX_W-1:0] fix_pix;    // RGBI expansion of the stage-1 index

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [PIX_W-1:0] mem_wdata;
  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_q;

  logic             s1_valid_q, s1_blank_q, s1_mode_q;
  logic [IDX_W-1:0] s1_idx_q;

  logic [PIX_W-1:0] pix_q, pix_d;
  logic             valid_o_q;

  // ---------------- init FSM ----------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (state_q == INIT) begin
      k_d = k_q + 1'b1;
      if (k_q == {IDX_W{1'b1}}) state_d = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  assign busy = (state_q == INIT);

  // ---------------- RGBI expansion ----------------
  // Each channel is MSB-first alternating {c, I, c, I, ...}.
  for (genvar gi = 0; gi < R_W; gi++) begin : g_red
    assign init_pix[PIX_W-1-gi] = (gi % 2 == 0) ? k_q[2]      : k_q[3];
    assign fix_pix[PIX_W-1-gi]  = (gi % 2 == 0) ? s1_idx_q[2] : s1_idx_q[3];
  end
  for (genvar gi = 0; gi < G_W; gi++) begin : g_green
    assign init_pix[G_W+B_W-1-gi] = (gi % 2 == 0) ? k_q[1]      : k_q[3];
    assign fix_pix[G_W+B_W-1-gi]  = (gi % 2 == 0) ? s1_idx_q[1] : s1_idx_q[3];
  end
  for (genvar gi = 0; gi < B_W; gi++) begin : g_blue
    assign init_pix[B_W-1-gi] = (gi % 2 == 0) ? k_q[0]      : k_q[3];
    assign fix_pix[B_W-1-gi]  = (gi % 2 == 0) ? s1_idx_q[0] : s1_idx_q[3];
  end

  // ---------------- palette RAM ----------------
  // The single write port is owned by the init sequencer while busy; user
  // writes are dropped then. Nothing is written while reset is asserted.
  assign mem_we    = !rst_i && (busy || bus.wr_en_i);
  assign mem_waddr = busy ? k_q      : bus.wr_addr_i;
  assign mem_wdata = busy ? init_pix : bus.wr_data_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read with write-first bypass on an address collision.
  always_ff @(posedge clk_i) begin
    if (mem_we && (mem_waddr == bus.color_i)) rd_q <= mem_wdata;
    else                                      rd_q <= mem[bus.color_i];
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= bus.valid_i;
      s1_blank_q <= bus.blank_i;
      s1_mode_q  <= bus.mode_i & ~busy;   // palette not usable until loaded
      s1_idx_q   <= bus.color_i;
    end
  end

  // ---------------- stage 2 ----------------
  always_comb begin
    pix_d = pix_q;
    if (s1_valid_q) begin
      if (s1_blank_q)     pix_d = '0;
      else if (s1_mode_q) pix_d = rd_q;
      else                pix_d = fix_pix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q     <= '0;
      valid_o_q <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      valid_o_q <= s1_valid_q;
    end
  end

  assign bus.red_o   = pix_q[PIX_W-1 -: R_W];
  assign bus.green_o = pix_q[G_W+B_W-1 -: G_W];
  assign bus.blue_o  = pix_q[B_W-1:0];
  assign bus.valid_o = valid_o_q;
  assign bus.busy_o  = busy;
endmodule

// File: tb/tb_palette_rgb.sv
module tb_palette_rgb;
  localparam int IDX_W = 4;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  palette_rgb_if #(.IDX_W(IDX_W), .R_W(R_W), .G_W(G_W), .B_W(B_W)) bus();

  palette_rgb #(.IDX_W(IDX_W), .R_W(R_W), .G_W(G_W), .B_W(B_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] rgb;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_pal [16];
  int          init_left = 16;
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference RGBI expansion for 5/6/5 outputs.
  function automatic logic [15:0] fx(input int idx);
    logic       i;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    i = idx[3];
    r = idx[2] ? (i ? 5'h1F : 5'h15) : (i ? 5'h0A : 5'h00);
    g = idx[1] ? (i ? 6'h3F : 6'h2A) : (i ? 6'h15 : 6'h00);
    b = idx[0] ? (i ? 5'h1F : 5'h15) : (i ? 5'h0A : 5'h00);
    return {r, g, b};
  endfunction

  // One clock of stimulus; called just after a rising edge.
  task automatic pix(input logic [3:0] c, input logic v, input logic b, input logic m,
                     input logic we, input logic [3:0] wa, input logic [15:0] wd);
    exp_t e;
    logic busy_now;
    busy_now = (init_left > 0);
    chk("busy", {31'd0, bus.busy_o}, {31'd0, busy_now});
    bus.color_i   = c;
    bus.valid_i   = v;
    bus.blank_i   = b;
    bus.mode_i    = m;
    bus.wr_en_i   = we;
    bus.wr_addr_i = wa;
    bus.wr_data_i = wd;
    if (v) begin
      if (b)                   e.rgb = 16'h0000;
      else if (m && !busy_now) e.rgb = (we && wa == c) ? wd : ref_pal[c];
      else                     e.rgb = fx(int'(c));
      e.due = cyc + 2;
      exp_q.push_back(e);
      $display("pix c=%0h mode=%0b blank=%0b we=%0b wa=%0h wd=%04h exp=%04h",
               c, m, b, we, wa, wd, e.rgb);
    end
    @(posedge clk);
    #1;
    if (busy_now) init_left--;
    else if (we) ref_pal[wa] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  task automatic do_reset(input int n, input logic pulse);
    rst           = 1'b1;
    bus.valid_i   = pulse;
    bus.color_i   = 4'hF;
    bus.blank_i   = 1'b0;
    bus.mode_i    = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = 4'h0;
    bus.wr_data_i = 16'h0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_valid_o", {31'd0, bus.valid_o}, 32'd0);
      chk("rst_rgb", {16'd0, bus.red_o, bus.green_o, bus.blue_o}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd1);
    end
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    exp_q.delete();
    init_left = 16;
    for (int i = 0; i < 16; i++) ref_pal[i] = fx(i);
    $display("reset cycles=%0d valid_pulse=%0b", n, pulse);
  endtask

  // Busy-period length; pixels with mode 1 and a write to entry 5 are
  // offered throughout and must be handled as fixed mode / ignored.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy_o === 1'b1 && cnt < 40) begin
      pix(cnt[3:0], 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 16'h1234);
      cnt++;
    end
    $display("busy cycles=%0d", cnt);
  endtask

  // Output monitor / scoreboard.
  logic [15:0] last_rgb = 16'h0;
  always @(negedge clk) begin
    logic [15:0] got;
    exp_t        e;
    got = {bus.red_o, bus.green_o, bus.blue_o};
    if (bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rgb", {16'd0, got}, {16'd0, e.rgb});
        chk("latency", cyc, e.due);
      end
    end else if (!rst) begin
      chk("hold", {16'd0, got}, {16'd0, last_rgb});
    end
    if (rst) last_rgb = 16'h0;
    else if (bus.valid_o === 1'b1) last_rgb = got;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0]  c, wa;
    logic        v, b, m, we;
    logic [15:0] wd;

    // Reset with a valid pulse that must not emerge.
    do_reset(3, 1'b1);
    count_busy(cnt);
    chk("busy_len", cnt, 32'd16);

    // Fixed-mode sweep with a couple of gaps.
    for (int i = 0; i < 16; i++) begin
      pix(i[3:0], 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
      if (i % 6 == 5) idle(1);
    end

    // Palette write then lookup; entry 5 keeps its default.
    pix(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 16'hF800);
    pix(4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    pix(4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);

    // Write-first bypass, then a plain read of the new entry.
    pix(4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 16'h07E0);
    pix(4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);

    // Blanking in both modes.
    pix(4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0);
    pix(4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    idle(2);

    // Random mix of modes, writes, blanking and bypass collisions.
    for (int i = 0; i < 60; i++) begin
      c  = 4'($urandom_range(0, 15));
      v  = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 7) == 0);
      m  = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0);
      wa = ($urandom_range(0, 3) == 0) ? c : 4'($urandom_range(0, 15));
      wd = 16'($urandom);
      pix(c, v, b, m, we, wa, wd);
    end
    idle(3);

    // Reset mid-INIT with pixels in flight.
    do_reset(1, 1'b0);
    for (int i = 0; i < 8; i++) pix(i[3:0], 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    do_reset(1, 1'b1);
    count_busy(cnt);
    chk("busy_len_restart", cnt, 32'd16);
    pix(4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    pix(4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    idle(3);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
